cpu_8096_alu_arb: RTL and testbench
===================================

Name: cpu_8096_alu_arb

Overview:
- Shares one 16-bit 8086-style integer ALU between two requesters: r0 (execute unit) and r1 (address/string unit).
- Round-robin arbitration; one registered response slot with a valid/ready handshake.
- Owns the architectural FLAGS register, updated atomically with each accepted op so back-to-back ADC/SBB chains see the correct CF.
- Sits between decode/execute and writeback in the 8096 core.

Parameters:
- TAG_W, 4, width of the opaque requester tag returned with each result.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- r0_valid  in  1  requester 0 op valid.
- r0_ready  out  1  requester 0 op accepted this cycle.
- r0_op  in  3  opcode: 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 AND, 5 OR, 6 XOR, 7 CMP.
- r0_a, r0_b  in  16  operands.
- r0_tag  in  TAG_W  returned with the result.
- r1_valid, r1_ready, r1_op, r1_a, r1_b, r1_tag: same as r0 for requester 1.
- rsp_valid  out  1  result slot full.
- rsp_ready  in  1  consumer takes the result.
- rsp_src  out  1  winning requester index.
- rsp_res  out  16  result.
- rsp_tag  out  TAG_W  tag of the op.
- flags_o  out  16  current FLAGS.
- flags_we  in  1  direct FLAGS write (POPF/IRET path).
- flags_wdata  in  16  value for a direct write.

Behaviour:
- Reset values:
  - rsp_valid=0; rsp_src=0; rsp_res=0; rsp_tag=0.
  - flags_o=16'h0002.
  - Round-robin pointer last_grant=1, so r0 wins the first tie.
- Slot free: can_accept = !rsp_valid | rsp_ready.
- Grant, combinational:
  - No grant if !can_accept or flags_we=1; a direct write stalls arbitration for that cycle.
  - Otherwise, one valid requester: that requester wins.
  - Otherwise, both valid: the requester != last_grant wins.
- r0_ready / r1_ready:
  - Asserted only for the winner.
  - Never both at once.
  - Ready may depend on valid.
- Accept (winner valid & ready):
  - Next edge: rsp_valid=1; rsp_res/rsp_tag/rsp_src load; last_grant=winner.
  - Latency: exactly 1 cycle from accept to rsp_valid.
  - Full throughput: one op per cycle while rsp_ready=1.
- Drain: rsp_valid & rsp_ready with no new accept -> rsp_valid=0 next edge.
- Holding:
  - rsp_* outputs are held stable while rsp_valid & !rsp_ready.
  - All requesters see ready=0 during the hold.
- Arithmetic (16-bit, cin = CF for ADC/SBB, else 0):
  - ADD/ADC: sum = a+b+cin in 17 bits; CF=sum[16]; AF = a[3:0]+b[3:0]+cin > 15; OF = (a15==b15)&(res15!=a15).
  - SUB/SBB/CMP: diff = a-b-cin in 17 bits; CF = borrow; AF = a[3:0] < b[3:0]+cin; OF = (a15!=b15)&(res15!=a15).
  - AND/OR/XOR: CF=OF=AF=0.
  - All ops: SF=res[15]; ZF=(res==0); PF = even parity of res[7:0].
  - CMP: rsp_res=a (result discarded); flags as SUB.
- FLAGS update:
  - On the accept edge, bits CF0/PF2/AF4/ZF6/SF7/OF11 are replaced.
  - TF/IF/DF are preserved.
- Direct write: flags_we=1 ->
  - flags = (flags_wdata & 16'h0FD5) | 16'h0002.
  - Bit1 is forced 1; bits 3, 5, 15:12 are forced 0.
- Invariant: bit1 of flags_o is always 1 and reserved bits are always 0.
- Reset mid-operation: asynchronous clear to the reset values; any in-flight result is lost.
- Requester protocol:
  - A requester must hold op/a/b/tag stable while valid & !ready.
  - The block does not check this.

Optional Feature:
- Macro: CPU_8096_ALU_ARB_STALL_CNT_EN.
- Defined: adds outputs stall_cnt0 and stall_cnt1 (16-bit each).
  - Each counts cycles its requester has valid=1 & ready=0.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst_n low mid-run -> rsp_valid=0, flags_o=16'h0002 immediately (asynchronous); first tie after reset goes to r0.
- r0 ADD a=16'hFFFF b=16'h0001 -> next cycle rsp_res=0, CF=1, ZF=1, AF=1, PF=1, OF=0; then r0 ADC a=0 b=0 -> rsp_res=1, CF=0.
- Both requesters valid every cycle, rsp_ready=1 -> grants alternate r0, r1, r0, r1; one response per cycle; rsp_tag matches the source.
- rsp_ready=0 for 3 cycles with a response pending -> rsp_* stable, r0_ready=r1_ready=0, flags unchanged; release -> the next op is accepted the same cycle.
- flags_we=1 with wdata=16'hFFFF while r0 valid -> flags_o=16'h0FD7, r0_ready=0 that cycle; r0 accepted the following cycle.
- SUB 16'h8000 - 16'h0001 -> res=16'h7FFF, OF=1, CF=0, SF=0; CMP with the same operands -> rsp_res=16'h8000, same flags.

Source files
------------

// File: rtl/cpu_8096_alu_arb.sv
// ============================================================================
// Module   : cpu_8096_alu_arb
// Brief    : Round-robin arbiter sharing one 16-bit 8086-style ALU between two
//            requesters, with a registered response slot and the FLAGS register.
//            Optional stall counters: define CPU_8096_ALU_ARB_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_8096_alu_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [2:0]       r0_op,
    input  logic [15:0]      r0_a,
    input  logic [15:0]      r0_b,
    input  logic [TAG_W-1:0] r0_tag,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [2:0]       r1_op,
    input  logic [15:0]      r1_a,
    input  logic [15:0]      r1_b,
    input  logic [TAG_W-1:0] r1_tag,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_src,
    output logic [15:0]      rsp_res,
    output logic [TAG_W-1:0] rsp_tag,

    output logic [15:0]      flags_o,
    input  logic             flags_we,
    input  logic [15:0]      flags_wdata
`ifdef CPU_8096_ALU_ARB_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt0,
    output logic [15:0]      stall_cnt1
`endif
);

    localparam logic [2:0]  c_OP_ADD    = 3'd0;
    localparam logic [2:0]  c_OP_ADC    = 3'd1;
    localparam logic [2:0]  c_OP_SUB    = 3'd2;
    localparam logic [2:0]  c_OP_SBB    = 3'd3;
    localparam logic [2:0]  c_OP_AND    = 3'd4;
    localparam logic [2:0]  c_OP_OR     = 3'd5;
    localparam logic [2:0]  c_OP_XOR    = 3'd6;
    localparam logic [2:0]  c_OP_CMP    = 3'd7;

    localparam logic [15:0] c_FLAGS_RST = 16'h0002;
    localparam logic [15:0] c_ALU_MASK  = 16'h08D5;
    localparam logic [15:0] c_WR_MASK   = 16'h0FD5;

    logic             r_rsp_valid;
    logic             r_rsp_src;
    logic [15:0]      r_rsp_res;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [15:0]      r_flags;
    logic             r_last_grant;

    logic             w_can_accept;
    logic             w_arb_en;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic             w_sel;
    logic [2:0]       w_op;
    logic [15:0]      w_a;
    logic [15:0]      w_b;
    logic [TAG_W-1:0] w_tag;

    logic             w_cin;
    logic [16:0]      w_sum17;
    logic [16:0]      w_diff17;
    logic [4:0]       w_nib_sum;
    logic [4:0]       w_nib_sub;
    logic [15:0]      w_res;
    logic             w_cf;
    logic             w_af;
    logic             w_of;
    logic [15:0]      w_rsp_data;
    logic [15:0]      w_flags_alu;
    logic [15:0]      w_flags_next;

    // A direct FLAGS write steals the cycle so an op never races a POPF.
    always_comb begin
        w_can_accept = !r_rsp_valid || rsp_ready;
        w_arb_en     = w_can_accept && !flags_we;
        w_gnt0       = w_arb_en && r0_valid && (!r1_valid || r_last_grant);
        w_gnt1       = w_arb_en && r1_valid && (!r0_valid || !r_last_grant);
        w_accept     = w_gnt0 || w_gnt1;
        w_sel        = w_gnt1;
        w_op         = w_sel ? r1_op  : r0_op;
        w_a          = w_sel ? r1_a   : r0_a;
        w_b          = w_sel ? r1_b   : r0_b;
        w_tag        = w_sel ? r1_tag : r0_tag;
    end

    assign r0_ready = w_gnt0;
    assign r1_ready = w_gnt1;

    always_comb begin
        w_cin     = ((w_op == c_OP_ADC) || (w_op == c_OP_SBB)) ? r_flags[0] : 1'b0;
        w_sum17   = {1'b0, w_a} + {1'b0, w_b} + {16'd0, w_cin};
        w_diff17  = {1'b0, w_a} - {1'b0, w_b} - {16'd0, w_cin};
        w_nib_sum = {1'b0, w_a[3:0]} + {1'b0, w_b[3:0]} + {4'd0, w_cin};
        w_nib_sub = {1'b0, w_b[3:0]} + {4'd0, w_cin};
        w_res     = 16'd0;
        w_cf      = 1'b0;
        w_af      = 1'b0;
        w_of      = 1'b0;
        case (w_op)
            c_OP_ADD, c_OP_ADC: begin
                w_res = w_sum17[15:0];
                w_cf  = w_sum17[16];
                w_af  = w_nib_sum[4];
                w_of  = (w_a[15] == w_b[15]) && (w_res[15] != w_a[15]);
            end
            c_OP_SUB, c_OP_SBB, c_OP_CMP: begin
                w_res = w_diff17[15:0];
                w_cf  = w_diff17[16];
                w_af  = ({1'b0, w_a[3:0]} < w_nib_sub);
                w_of  = (w_a[15] != w_b[15]) && (w_res[15] != w_a[15]);
            end
            c_OP_AND: w_res = w_a & w_b;
            c_OP_OR:  w_res = w_a | w_b;
            c_OP_XOR: w_res = w_a ^ w_b;
            default:  w_res = 16'd0;
        endcase
        w_rsp_data   = (w_op == c_OP_CMP) ? w_a : w_res;
        w_flags_alu  = {4'b0000, w_of, 3'b000, w_res[15], (w_res == 16'd0), 1'b0,
                        w_af, 1'b0, ~^w_res[7:0], 1'b0, w_cf};
        w_flags_next = (r_flags & ~c_ALU_MASK) | w_flags_alu;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_src    <= 1'b0;
            r_rsp_res    <= 16'd0;
            r_rsp_tag    <= '0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_src    <= w_sel;
            r_rsp_res    <= w_rsp_data;
            r_rsp_tag    <= w_tag;
            r_last_grant <= w_sel;
        end else if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    // Accept and direct write are mutually exclusive, so the order here is moot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= c_FLAGS_RST;
        end else if (flags_we) begin
            r_flags <= (flags_wdata & c_WR_MASK) | c_FLAGS_RST;
        end else if (w_accept) begin
            r_flags <= w_flags_next;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_src   = r_rsp_src;
    assign rsp_res   = r_rsp_res;
    assign rsp_tag   = r_rsp_tag;
    assign flags_o   = r_flags;

`ifdef CPU_8096_ALU_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt0;
    logic [15:0] r_stall_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt0 <= 16'd0;
            r_stall_cnt1 <= 16'd0;
        end else begin
            if (r0_valid && !w_gnt0 && (r_stall_cnt0 != 16'hFFFF))
                r_stall_cnt0 <= r_stall_cnt0 + 16'd1;
            if (r1_valid && !w_gnt1 && (r_stall_cnt1 != 16'hFFFF))
                r_stall_cnt1 <= r_stall_cnt1 + 16'd1;
        end
    end

    assign stall_cnt0 = r_stall_cnt0;
    assign stall_cnt1 = r_stall_cnt1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_8096_alu_arb.sv
// ============================================================================
// Module   : tb_cpu_8096_alu_arb
// Brief    : Self-checking bench for cpu_8096_alu_arb: directed literal cases
//            plus randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_8096_alu_arb;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             r0_valid, r1_valid;
    logic             r0_ready, r1_ready;
    logic [2:0]       r0_op, r1_op;
    logic [15:0]      r0_a, r0_b, r1_a, r1_b;
    logic [TAG_W-1:0] r0_tag, r1_tag;
    logic             rsp_valid, rsp_ready, rsp_src;
    logic [15:0]      rsp_res;
    logic [TAG_W-1:0] rsp_tag;
    logic [15:0]      flags_o;
    logic             flags_we;
    logic [15:0]      flags_wdata;
`ifdef CPU_8096_ALU_ARB_STALL_CNT_EN
    logic [15:0]      stall_cnt0, stall_cnt1;
`endif

    cpu_8096_alu_arb #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b), .r0_tag(r0_tag),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b), .r1_tag(r1_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
        .rsp_res(rsp_res), .rsp_tag(rsp_tag),
        .flags_o(flags_o), .flags_we(flags_we), .flags_wdata(flags_wdata)
`ifdef CPU_8096_ALU_ARB_STALL_CNT_EN
        , .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: the response slot, FLAGS and who went last.
    bit               m_valid;
    bit               m_src;
    logic [15:0]      m_res;
    logic [TAG_W-1:0] m_tag;
    logic [15:0]      m_flags;
    bit               m_last;
    bit               m_g0, m_g1;
    bit               c_g0, c_g1, c_can;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_src = 0; m_res = 16'h0; m_tag = '0;
        m_flags = 16'h0002; m_last = 1; m_g0 = 0; m_g1 = 0;
    endtask

    // Plain-integer ALU semantics; overflow is true signed range overflow.
    function automatic void alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                input bit cf_in, output logic [15:0] res, output logic [15:0] fl);
        int ia = int'(a);
        int ib = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int c  = 0;
        int r  = 0;
        int sr = 0;
        bit cf = 0, af = 0, of = 0, pf;
        logic [15:0] v;
        case (op)
            3'd0, 3'd1: begin
                c  = (op == 3'd1) ? int'(cf_in) : 0;
                r  = ia + ib + c;
                sr = sa + sb + c;
                cf = (r > 65535);
                af = ((ia % 16) + (ib % 16) + c) > 15;
                of = (sr > 32767) || (sr < -32768);
            end
            3'd2, 3'd3, 3'd7: begin
                c  = (op == 3'd3) ? int'(cf_in) : 0;
                r  = ia - ib - c;
                sr = sa - sb - c;
                cf = (r < 0);
                af = (ia % 16) < ((ib % 16) + c);
                of = (sr > 32767) || (sr < -32768);
            end
            3'd4: r = int'(a & b);
            3'd5: r = int'(a | b);
            default: r = int'(a ^ b);
        endcase
        v  = r[15:0];
        pf = ($countones(v[7:0]) % 2) == 0;
        fl = 16'h0;
        fl[0]  = cf;
        fl[2]  = pf;
        fl[4]  = af;
        fl[6]  = (v == 16'h0);
        fl[7]  = v[15];
        fl[11] = of;
        res = (op == 3'd7) ? a : v;
    endfunction

    // Applies the decision made during the cycle that just ended at this edge.
    task automatic model_edge();
        logic [15:0] res, fl;
        if (!rst_n) return;
        if (m_g0 || m_g1) begin
            if (m_g1) alu(r1_op, r1_a, r1_b, m_flags[0], res, fl);
            else      alu(r0_op, r0_a, r0_b, m_flags[0], res, fl);
            m_flags = (m_flags & ~16'h08D5) | fl;
            m_valid = 1;
            m_src   = m_g1;
            m_res   = res;
            m_tag   = m_g1 ? r1_tag : r0_tag;
            m_last  = m_g1;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        if (flags_we) m_flags = (flags_wdata & 16'h0FD5) | 16'h0002;
    endtask

    // Compare process: decide the grant from the rules, then check everything.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_g0 = 0; m_g1 = 0;
        end else begin
            c_can = !m_valid || rsp_ready;
            c_g0 = 0; c_g1 = 0;
            if (c_can && !flags_we) begin
                if (r0_valid && r1_valid) begin
                    if (m_last) c_g0 = 1; else c_g1 = 1;
                end else if (r0_valid) c_g0 = 1;
                else if (r1_valid) c_g1 = 1;
            end
            m_g0 = c_g0; m_g1 = c_g1;
            chk("r0_ready",  32'(r0_ready),  32'(m_g0));
            chk("r1_ready",  32'(r1_ready),  32'(m_g1));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("rsp_src",   32'(rsp_src),   32'(m_src));
            chk("rsp_res",   32'(rsp_res),   32'(m_res));
            chk("rsp_tag",   32'(rsp_tag),   32'(m_tag));
            chk("flags",     32'(flags_o),   32'(m_flags));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_r0(input bit v, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [TAG_W-1:0] t);
        r0_valid = v; r0_op = op; r0_a = a; r0_b = b; r0_tag = t;
    endtask

    task automatic set_r1(input bit v, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [TAG_W-1:0] t);
        r1_valid = v; r1_op = op; r1_a = a; r1_b = b; r1_tag = t;
    endtask

    function automatic logic [15:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Held requests stay frozen until granted.
    task automatic drive_random();
        if (!(r0_valid && !m_g0))
            set_r0($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
                   TAG_W'($urandom));
        if (!(r1_valid && !m_g1))
            set_r1($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
                   TAG_W'($urandom));
        rsp_ready   = ($urandom_range(0, 3) != 0);
        flags_we    = ($urandom_range(0, 15) == 0);
        flags_wdata = 16'($urandom);
    endtask

    initial begin
        rst_n = 0;
        set_r0(0, 3'd0, 16'h0, 16'h0, '0);
        set_r1(0, 3'd0, 16'h0, 16'h0, '0);
        rsp_ready = 0; flags_we = 0; flags_wdata = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_flags",     32'(flags_o),   32'h0002);
        chk("rst_rsp_res",   32'(rsp_res),   32'h0);

        // ADD FFFF+1, then ADC carries the resulting CF.
        tick();
        rsp_ready = 1;
        set_r0(1, 3'd0, 16'hFFFF, 16'h0001, 4'h3);
        #1 chk("add_ready", 32'(r0_ready), 32'd1);
        tick();
        chk("add_res",   32'(rsp_res), 32'h0000);
        chk("add_flags", 32'(flags_o), 32'h0057);
        set_r0(1, 3'd1, 16'h0000, 16'h0000, 4'h4);
        tick();
        chk("adc_res",   32'(rsp_res), 32'h0001);
        chk("adc_flags", 32'(flags_o), 32'h0002);
        set_r0(1, 3'd2, 16'h8000, 16'h0001, 4'h5);
        tick();
        chk("sub_res",   32'(rsp_res), 32'h7FFF);
        chk("sub_flags", 32'(flags_o), 32'h0816);
        set_r0(1, 3'd7, 16'h8000, 16'h0001, 4'h6);
        tick();
        chk("cmp_res",   32'(rsp_res), 32'h8000);
        chk("cmp_flags", 32'(flags_o), 32'h0816);
        chk("cmp_tag",   32'(rsp_tag), 32'h6);

        // Direct FLAGS write stalls arbitration for one cycle.
        set_r0(1, 3'd0, 16'h0001, 16'h0001, 4'h9);
        flags_we = 1; flags_wdata = 16'hFFFF;
        #1 chk("we_stall", 32'(r0_ready), 32'd0);
        tick();
        chk("we_flags", 32'(flags_o), 32'h0FD7);
        flags_we = 0;
        #1 chk("we_after", 32'(r0_ready), 32'd1);
        tick();
        chk("add2_res",   32'(rsp_res), 32'h0002);
        chk("add2_flags", 32'(flags_o), 32'h0702);

        // Consumer back-pressure for three cycles.
        rsp_ready = 0;
        set_r0(1, 3'd6, 16'hF0F0, 16'h0F0F, 4'h7);
        set_r1(1, 3'd5, 16'h0001, 16'h0002, 4'h8);
        #1;
        chk("hold_r0", 32'(r0_ready), 32'd0);
        chk("hold_r1", 32'(r1_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_res",   32'(rsp_res),   32'h0002);
            chk("hold_flags", 32'(flags_o),   32'h0702);
            chk("hold_any",   32'(r0_ready | r1_ready), 32'd0);
        end
        tick();
        rsp_ready = 1;
        #1 chk("release_r1", 32'(r1_ready), 32'd1);

        // Both requesters busy: grants alternate, tag follows source.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_src",   32'(rsp_src),   32'((i % 2) == 0));
            chk("alt_valid", 32'(rsp_valid), 32'd1);
            chk("alt_tag",   32'(rsp_tag),   ((i % 2) == 0) ? 32'h8 : 32'h7);
        end

        repeat (1500) begin
            tick();
            drive_random();
        end

        // Asynchronous reset between edges, then the first tie goes to r0.
        tick();
        drive_random();
        #2 rst_n = 0;
        #1;
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        chk("arst_flags", 32'(flags_o),   32'h0002);
        model_reset();
        tick();
        set_r0(1, 3'd0, 16'h1234, 16'h1111, 4'hA);
        set_r1(1, 3'd2, 16'h4444, 16'h0004, 4'hB);
        rsp_ready = 1; flags_we = 0;
        #1 rst_n = 1;
        #1;
        chk("tie_r0", 32'(r0_ready), 32'd1);
        chk("tie_r1", 32'(r1_ready), 32'd0);

        repeat (500) begin
            tick();
            drive_random();
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
